load_store_unit: RTL and testbench
==================================

# load_store_unit

Core-side initiator for the single-cycle CPU's data memory. It accepts load/store requests from the execute stage over a valid/ready handshake and always issues full-word accesses to data memory. Sub-word lane extraction and sign/zero extension for loads are done in this block. Sub-word stores use read-modify-write, because the memory replaces the whole word on any write. Results return over a valid/ready response channel.

## Interface
- DATA_WIDTH, 32, data path width; only 32 is supported.
- ADDR_WIDTH, 32, byte address width.
- clk  input  1  rising-edge clock for all state.
- rstn  input  1  synchronous reset, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; high only in IDLE with rstn high.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data, right-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes response.
- rsp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_misaligned  output  1  request was misaligned or illegal; no memory access was made.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable; memory commits on the falling edge.
- mem_maskmode  output  2  constant 2'b10 (word).
- mem_sext  output  1  constant 0.
- mem_address  output  ADDR_WIDTH  {addr_q[ADDR_WIDTH-1:2], 2'b00}.
- mem_write_data  output  DATA_WIDTH  full word to write.
- mem_read_data  input  DATA_WIDTH  combinational read data from memory.

## Operation
- FSM states and their outputs:
  - IDLE: req_ready=1.
  - READ: mem_read=1.
  - WRITE: mem_write=1.
  - RESP: rsp_valid=1.
- All outputs are decoded from registered state and registered fields only; no request input is combinationally passed to memory.
- Accept: on req_valid && req_ready, register addr, wdata, size, we and unsigned.
- Misalignment: half with addr[0]=1, word with addr[1:0]≠0, or size=11.
  - IDLE→RESP with rsp_misaligned=1 and rsp_rdata=0.
  - mem_read and mem_write never assert.
- Load: IDLE→READ→RESP.
  - At the end of READ, capture mem_read_data and extract the lane:
    - byte: bits [8*addr[1:0] +: 8].
    - half: bits [16*addr[1] +: 16].
  - Extend per unsigned_q and register the result into rsp_rdata.
- Word store: IDLE→WRITE→RESP. mem_write_data = wdata_q.
- Sub-word store: IDLE→READ→WRITE→RESP.
  - At the end of READ, register a merged word: the read word with the addressed lane replaced by wdata_q[7:0] or wdata_q[15:0].
  - WRITE drives the merged word.
- RESP: hold rsp_valid, rsp_rdata and rsp_misaligned stable until rsp_ready, then go to IDLE.
- No new request is accepted while a response is pending.
- Outputs while idle: mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.

## Timing
- Latency in rising edges from the accept edge to the edge on which rsp_valid goes high:
  - load: 2.
  - word store: 2.
  - sub-word store: 3.
  - misaligned: 1.
- Minimum request-to-request spacing is latency+1 cycles when rsp_ready is held high.
- mem_write is high for exactly one cycle per store. The write commits on that cycle's falling edge.
- mem_read is high for exactly one cycle per load or sub-word store.
- Reset (rstn=0 sampled at a rising edge):
  - Next state is IDLE; all registers clear.
  - rsp_valid=0, rsp_rdata=0, rsp_misaligned=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
  - req_ready=0 while rstn=0 and 1 after release.
- Reset during READ of a sub-word store must prevent any mem_write. The operation is dropped with no response.
- Reset sampled during the WRITE cycle: that cycle's write still commits on the falling edge, and the response is dropped.

## Structure
- Package lsu_pkg holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - MASK_WORD=2'b10.
  - the FSM state enum: IDLE, READ, WRITE, RESP.
- Sub-module lsu_lane_align (combinational) takes word, offset, size, unsigned and wdata, and outputs the extracted load value and the merged store word.
- load_store_unit contains only the FSM and the registers.

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load at 0x10: one mem_write pulse with mem_address=0x10; the load returns rsp_rdata=0xDEADBEEF; both responses arrive 2 cycles after accept.
- Memory word 0x11223344 at 0x10, byte store 0xA5 at 0x11: one READ then one WRITE of 0x1122A544.
  - Follow-up signed byte load at 0x11 returns 0xFFFFFFA5.
  - Follow-up unsigned byte load at 0x11 returns 0x000000A5.
- Memory word 0x80013344, half load at 0x12: signed returns 0xFFFF8001; unsigned returns 0x00008001.
- Word load at 0x13 and half load at 0x11: mem_read and mem_write stay 0; rsp_misaligned=1 and rsp_rdata=0 one cycle after accept.
- Load with rsp_ready held low 3 cycles: rsp_valid and rsp_rdata stable and req_ready=0 throughout; IDLE one cycle after rsp_ready rises.
- rstn pulled low during READ of a byte store: no mem_write ever, all outputs 0, memory word unchanged, req_ready=1 the cycle after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, FSM state type and alignment helper for the load/store unit
package lsu_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] MASK_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      RESP  = 2'b11
   } lsu_state_t;

   // Illegal size, or an access that does not sit on its natural boundary
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      logic bad;
      bad = 1'b0;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = offset[0];
         SIZE_WORD: bad = (offset != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte/half lane extraction with extension, and sub-word store merge
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   output logic [31:0] load_value,
   output logic [31:0] merged
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign byte_lane = word[{offset, 3'b000} +: 8];
   assign half_lane = word[{offset[1], 4'b0000} +: 16];

   // Extend the addressed lane into a right-aligned load result
   always_comb begin
      load_value = word;
      case (size)
         SIZE_BYTE: load_value = is_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
         SIZE_HALF: load_value = is_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
         default:   load_value = word;
      endcase
   end

   // Replace only the addressed lane of the read word with the store data
   always_comb begin
      merged = word;
      case (size)
         SIZE_BYTE: merged[{offset, 3'b000} +: 8]     = wdata[7:0];
         SIZE_HALF: merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
         default:   merged = wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - request/response FSM issuing full-word data memory accesses
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_misaligned,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [1:0]            mem_maskmode,
   output logic                  mem_sext,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data
);

   lsu_state_t            state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] store_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            size_q;
   logic                  we_q;
   logic                  unsigned_q;
   logic                  misaligned_q;
   logic [DATA_WIDTH-1:0] load_value;
   logic [DATA_WIDTH-1:0] merged;

   lsu_lane_align u_align (
      .word        (mem_read_data),
      .offset      (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .wdata       (store_q),
      .load_value  (load_value),
      .merged      (merged)
   );

   assign req_ready      = (state == IDLE) && rstn;
   assign rsp_valid      = (state == RESP);
   assign rsp_rdata      = (state == RESP) ? rdata_q : '0;
   assign rsp_misaligned = (state == RESP) && misaligned_q;
   assign mem_read       = (state == READ);
   assign mem_write      = (state == WRITE);
   assign mem_maskmode   = MASK_WORD;
   assign mem_sext       = 1'b0;
   assign mem_address    = (state == READ || state == WRITE) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign mem_write_data = (state == WRITE) ? store_q : '0;

   // Sequence accept -> optional read -> optional write -> response, holding fields in registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state        <= IDLE;
         addr_q       <= '0;
         store_q      <= '0;
         rdata_q      <= '0;
         size_q       <= '0;
         we_q         <= 1'b0;
         unsigned_q   <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q     <= req_addr;
                  store_q    <= req_wdata;
                  size_q     <= req_size;
                  we_q       <= req_we;
                  unsigned_q <= req_unsigned;
                  rdata_q    <= '0;
                  if (is_misaligned(req_size, req_addr[1:0])) begin
                     misaligned_q <= 1'b1;
                     state        <= RESP;
                  end else begin
                     misaligned_q <= 1'b0;
                     // Only full-word stores skip the read; sub-word stores need the old word
                     state        <= (req_we && req_size == SIZE_WORD) ? WRITE : READ;
                  end
               end
            end
            READ: begin
               if (we_q) begin
                  store_q <= merged;
                  state   <= WRITE;
               end else begin
                  rdata_q <= load_value;
                  state   <= RESP;
               end
            end
            WRITE: state <= RESP;
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit with a word memory model
module tb_load_store_unit;

   logic        clk;
   logic        rstn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_misaligned;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_maskmode;
   logic        mem_sext;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   logic [31:0] mem [0:63];
   logic        poke_en;
   logic [5:0]  poke_idx;
   logic [31:0] poke_data;
   int          write_pulses;

   int checks;
   int errors;

   int          lat;
   int          nread;
   int          nwrite;
   logic [31:0] w_addr;
   logic [31:0] w_data;
   logic [31:0] got_rdata;
   logic        got_mis;
   logic [31:0] held;

   load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_size       (req_size),
      .req_unsigned   (req_unsigned),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_rdata      (rsp_rdata),
      .rsp_misaligned (rsp_misaligned),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_maskmode   (mem_maskmode),
      .mem_sext       (mem_sext),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_address[7:2]];

   // Memory commits on the falling edge; bench preloads share the same port
   always @(negedge clk) begin
      if (mem_write) begin
         mem[mem_address[7:2]] <= mem_write_data;
         write_pulses          <= write_pulses + 1;
      end else if (poke_en) begin
         mem[poke_idx] <= poke_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [5:0] idx, input logic [31:0] data);
      poke_idx  = idx;
      poke_data = data;
      poke_en   = 1'b1;
      @(negedge clk);
      #1;
      poke_en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Issue one request and follow it to rsp_valid, tallying memory activity on the way
   task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat       = 1;
      nread     = 0;
      nwrite    = 0;
      w_addr    = '0;
      w_data    = '0;
      while (!rsp_valid && lat < 8) begin
         if (mem_read) nread++;
         if (mem_write) begin
            nwrite++;
            w_addr = mem_address;
            w_data = mem_write_data;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      got_rdata = rsp_rdata;
      got_mis   = rsp_misaligned;
   endtask

   task automatic to_idle();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      write_pulses = 0;
      poke_en      = 1'b0;
      poke_idx     = '0;
      poke_data    = '0;
      rstn         = 1'b0;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      rsp_ready    = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_misaligned", {31'b0, rsp_misaligned}, 32'd0);
      check("rst_mem_read", {31'b0, mem_read}, 32'd0);
      check("rst_mem_write", {31'b0, mem_write}, 32'd0);
      check("rst_mem_address", mem_address, 32'd0);
      check("rst_mem_write_data", mem_write_data, 32'd0);
      check("rst_req_ready", {31'b0, req_ready}, 32'd0);
      check("mem_maskmode", {30'b0, mem_maskmode}, 32'd2);
      check("mem_sext", {31'b0, mem_sext}, 32'd0);

      rstn = 1'b1;
      @(posedge clk);
      #1;
      check("req_ready_after_release", {31'b0, req_ready}, 32'd1);

      poke(6'd0, 32'h0);
      poke(6'd4, 32'h0);

      // Word store then word load at 0x10
      txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      check("sw_latency", lat, 32'd2);
      check("sw_nread", nread, 32'd0);
      check("sw_nwrite", nwrite, 32'd1);
      check("sw_addr", w_addr, 32'h10);
      check("sw_data", w_data, 32'hDEADBEEF);
      check("sw_rdata", got_rdata, 32'h0);
      check("sw_mis", {31'b0, got_mis}, 32'd0);
      to_idle();
      check("idle_mem_address", mem_address, 32'd0);
      check("idle_mem_write_data", mem_write_data, 32'd0);
      check("sw_mem_word", mem[4], 32'hDEADBEEF);

      txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      check("lw_latency", lat, 32'd2);
      check("lw_nread", nread, 32'd1);
      check("lw_nwrite", nwrite, 32'd0);
      check("lw_rdata", got_rdata, 32'hDEADBEEF);
      to_idle();

      // Byte store read-modify-write
      poke(6'd4, 32'h11223344);
      txn(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5);
      check("sb_latency", lat, 32'd3);
      check("sb_nread", nread, 32'd1);
      check("sb_nwrite", nwrite, 32'd1);
      check("sb_addr", w_addr, 32'h10);
      check("sb_data", w_data, 32'h1122A544);
      to_idle();
      check("sb_mem_word", mem[4], 32'h1122A544);

      txn(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
      check("lb_signed", got_rdata, 32'hFFFFFFA5);
      to_idle();
      txn(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
      check("lbu_unsigned", got_rdata, 32'h000000A5);
      to_idle();

      // Half loads, top byte load, and half store
      poke(6'd4, 32'h80013344);
      txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
      check("lh_signed", got_rdata, 32'hFFFF8001);
      check("lh_latency", lat, 32'd2);
      to_idle();
      txn(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
      check("lhu_unsigned", got_rdata, 32'h00008001);
      to_idle();
      txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
      check("lb_top_signed", got_rdata, 32'hFFFFFF80);
      to_idle();
      txn(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
      check("lbu_low", got_rdata, 32'h00000044);
      to_idle();
      txn(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF);
      check("sh_latency", lat, 32'd3);
      check("sh_data", w_data, 32'hBEEF3344);
      to_idle();
      txn(1'b1, 2'b01, 1'b0, 32'h10, 32'h00005566);
      check("sh_low_data", w_data, 32'hBEEF5566);
      to_idle();

      // Misaligned and illegal requests
      txn(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
      check("mis_w_latency", lat, 32'd1);
      check("mis_w_flag", {31'b0, got_mis}, 32'd1);
      check("mis_w_rdata", got_rdata, 32'h0);
      check("mis_w_nread", nread + nwrite, 32'd0);
      to_idle();
      txn(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
      check("mis_h_latency", lat, 32'd1);
      check("mis_h_flag", {31'b0, got_mis}, 32'd1);
      check("mis_h_rdata", got_rdata, 32'h0);
      to_idle();
      txn(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF);
      check("illegal_size_flag", {31'b0, got_mis}, 32'd1);
      check("illegal_size_latency", lat, 32'd1);
      to_idle();
      check("mis_mem_untouched", mem[4], 32'hBEEF5566);

      // Response back-pressure
      rsp_ready = 1'b0;
      txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      check("stall_rdata", got_rdata, 32'hBEEF5566);
      held = rsp_rdata;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         check("stall_rdata_stable", rsp_rdata, held);
         check("stall_req_ready", {31'b0, req_ready}, 32'd0);
      end
      to_idle();
      check("after_stall_req_ready", {31'b0, req_ready}, 32'd1);
      check("after_stall_rsp_valid", {31'b0, rsp_valid}, 32'd0);

      // Reset during READ of a byte store
      poke(6'd4, 32'h11223344);
      held         = write_pulses;
      req_valid    = 1'b1;
      req_we       = 1'b1;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'h11;
      req_wdata    = 32'h000000A5;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("rr_mem_read", {31'b0, mem_read}, 32'd1);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      check("rr_mem_read_off", {31'b0, mem_read}, 32'd0);
      check("rr_mem_write", {31'b0, mem_write}, 32'd0);
      check("rr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rr_mem_address", mem_address, 32'd0);
      check("rr_req_ready_low", {31'b0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check("rr_req_ready_release", {31'b0, req_ready}, 32'd1);
      check("rr_rsp_valid_after", {31'b0, rsp_valid}, 32'd0);
      check("rr_no_write", write_pulses, held);
      check("rr_mem_unchanged", mem[4], 32'h11223344);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
